fifo_write_arbiter: RTL and testbench

//  Round-robin arbiter that shares the write port of one async_fifo among NUM_REQ requesters.

---
 rtl/fifo_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin, burst-locked arbiter that shares one async FIFO write port among NUM_REQ
//   requesters. A grant is held until the owner transfers a 'last' beat or MAX_BURST beats.
//   Every beat written to the FIFO is tagged with the owner's index in its upper IDW bits.
//   Lives entirely in the FIFO write-clock domain.
//
// Ports
//   clk                write-side clock
//   rst_n              asynchronous active-low reset
//   req_valid_i        per-requester beat valid
//   req_last_i         per-requester last beat of burst (qualified by valid)
//   req_data_i         requester r payload at [r*WIDTH +: WIDTH]
//   req_ready_o        per-requester accept; beat moves when valid && ready at posedge clk
//   fifo_full_i        FIFO full flag
//   fifo_wr_en_o       FIFO write enable
//   fifo_write_data_o  {owner id, payload} to the FIFO
//   grant_o            one-hot current owner, 0 when idle
//   busy_o             high while a burst is granted
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 8,
    localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_en_o,
    output logic [IDW+WIDTH-1:0]     fifo_write_data_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o
);

    // beat_cnt only ever holds 0 .. MAX_BURST-1
    localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    state_e          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  owner_q;
    logic [CW-1:0]   beat_cnt_q;

    // Round-robin search
    logic [2*NUM_REQ-2:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [IDW-1:0]       pick_off;
    logic [IDW:0]         pick_sum;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_found;

    // Owner-side datapath
    logic                 burst;
    logic                 owner_valid;
    logic                 owner_last;
    logic [WIDTH-1:0]     owner_data;
    logic [NUM_REQ-1:0]   owner_onehot;
    logic                 transfer;
    logic                 burst_end;
    logic [IDW-1:0]       next_rr;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr; the lowest set bit of the
    // rotated vector is then the round-robin winner, offset from rr_ptr.
    always_comb begin
        valid_dbl  = {req_valid_i[NUM_REQ-2:0], req_valid_i};
        valid_rot  = valid_dbl[rr_ptr_q +: NUM_REQ];
        pick_off   = '0;
        pick_found = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                pick_found = 1'b1;
                pick_off   = IDW'(j);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (IDW+1)'(NUM_REQ)) begin
            pick_idx = IDW'(pick_sum - (IDW+1)'(NUM_REQ));
        end else begin
            pick_idx = IDW'(pick_sum);
        end
    end

    always_comb begin
        burst        = (state_q == StBurst);
        owner_valid  = req_valid_i[owner_q];
        owner_last   = req_last_i[owner_q];
        owner_data   = req_data_i[owner_q*WIDTH +: WIDTH];
        owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
        transfer     = burst && owner_valid && !fifo_full_i;
        burst_end    = owner_last || (beat_cnt_q == CW'(MAX_BURST - 1));
        next_rr      = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        owner_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= StBurst;
                    end
                end
                StBurst: begin
                    // Full or an owner without valid simply holds everything.
                    if (transfer) begin
                        if (burst_end) begin
                            state_q    <= StIdle;
                            rr_ptr_q   <= next_rr;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        busy_o            = burst;
        grant_o           = burst ? owner_onehot : '0;
        req_ready_o       = (burst && !fifo_full_i) ? owner_onehot : '0;
        fifo_wr_en_o      = transfer;
        fifo_write_data_o = burst ? {owner_q, owner_data} : '0;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Self-checking bench for fifo_write_arbiter (NUM_REQ=4, WIDTH=8, MAX_BURST=4).
//   Per-requester source queues drive valid/last/data and advance on accepted beats.
//   Each directed test pushes its hand-computed FIFO words into a scoreboard queue; an
//   independent monitor pops and compares whenever fifo_wr_en_o is seen.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [9:0]      fifo_wdata;
    logic [NR-1:0]   grant;
    logic            busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ   (NR),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_last_i        (req_last),
        .req_data_i        (req_data),
        .req_ready_o       (req_ready),
        .fifo_full_i       (fifo_full),
        .fifo_wr_en_o      (fifo_wr_en),
        .fifo_write_data_o (fifo_wdata),
        .grant_o           (grant),
        .busy_o            (busy)
    );

    int n_checks;
    int n_fail;

    // Source queues: {last, data}
    logic [8:0]    src_mem [NR][32];
    int            src_wr [NR];
    int            src_rd [NR];
    logic [NR-1:0] acc = '0;

    // Scoreboard and write log
    logic [9:0] exp_q [$];
    int         wr_count = 0;
    int         wr_cyc [64];
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat acceptance seen before the edge that commits it
    always @(negedge clk) acc <= req_valid & req_ready;

    // Source driver: advance on accepted beat, flush while in reset
    initial begin
        for (int r = 0; r < NR; r++) src_rd[r] = 0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (!rst_n) src_rd[r] = src_wr[r];
                else if (acc[r]) src_rd[r] = src_rd[r] + 1;
                if (src_rd[r] != src_wr[r]) begin
                    req_valid[r]       = 1'b1;
                    req_last[r]        = src_mem[r][src_rd[r]][8];
                    req_data[r*W +: W] = src_mem[r][src_rd[r]][7:0];
                end else begin
                    req_valid[r]       = 1'b0;
                    req_last[r]        = 1'b0;
                    req_data[r*W +: W] = '0;
                end
            end
        end
    end

    // Monitor
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && fifo_wr_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL fifo_write: got %h, required no write", fifo_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (fifo_wdata !== e || fifo_full !== 1'b0) begin
                        n_fail++;
                        $display("FAIL fifo_write: got %h full=%b, required %h full=0",
                                 fifo_wdata, fifo_full, e);
                    end
                end
                if (wr_count < 64) wr_cyc[wr_count] = cyc;
                wr_count++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        src_mem[r][src_wr[r]] = {last, d};
        src_wr[r]             = src_wr[r] + 1;
    endtask

    task automatic expw(input logic [9:0] v);
        exp_q.push_back(v);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d words pending busy=%b, required 0 and idle",
                     name, exp_q.size(), busy);
        end
        tick();
    endtask

    // Returns at posedge+2 of the edge that committed write number target-1
    task automatic wait_writes(input string name, input int target);
        int k;
        k = 0;
        while (wr_count < target && k < 100) begin
            @(posedge clk);
            k++;
        end
        #2;
        n_checks++;
        if (wr_count < target) begin
            n_fail++;
            $display("FAIL %s_wait: got %0d writes, required %0d", name, wr_count, target);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"},  32'(busy), 32'd0);
        chk({name, "_grant"}, 32'(grant), 32'd0);
        chk({name, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        chk({name, "_wdata"}, 32'(fifo_wdata), 32'd0);
        chk({name, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        n_checks  = 0;
        n_fail    = 0;
        fifo_full = 1'b0;
        for (int r = 0; r < NR; r++) src_wr[r] = 0;

        // Reset state, before any clock edge
        #2;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // 1: single requester r2, 3-beat burst, then search resumes at r3
        b = wr_count;
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        expw(10'h211); expw(10'h222); expw(10'h233);
        drain("t1");
        chk("t1_back2back_a", 32'(wr_cyc[b+1] - wr_cyc[b]), 32'd1);
        chk("t1_back2back_b", 32'(wr_cyc[b+2] - wr_cyc[b+1]), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        push(0, 8'hA0, 1'b1); push(3, 8'hA3, 1'b1);
        expw(10'h3A3); expw(10'h0A0);
        drain("t1_rr");

        // 2: r0 and r1 two-beat bursts after reset, bubble between grants, two rounds
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        b = wr_count;
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        expw(10'h001); expw(10'h002); expw(10'h111); expw(10'h112);
        drain("t2a");
        chk("t2_gap_r0", 32'(wr_cyc[b+1] - wr_cyc[b]), 32'd1);
        chk("t2_bubble", 32'(wr_cyc[b+2] - wr_cyc[b+1]), 32'd2);
        chk("t2_gap_r1", 32'(wr_cyc[b+3] - wr_cyc[b+2]), 32'd1);
        push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
        push(1, 8'h13, 1'b0); push(1, 8'h14, 1'b1);
        expw(10'h003); expw(10'h004); expw(10'h113); expw(10'h114);
        drain("t2b");

        // 3: full for 4 cycles after beat 1 of 3 (r3, rr_ptr=2)
        b = wr_count;
        push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
        expw(10'h331); expw(10'h332); expw(10'h333);
        wait_writes("t3", b + 1);
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_stall_wr_en", 32'(fifo_wr_en), 32'd0);
            chk("t3_stall_ready", 32'(req_ready), 32'd0);
            chk("t3_stall_grant", 32'(grant), 32'h8);
            @(posedge clk);
        end
        #2;
        fifo_full = 1'b0;
        drain("t3");
        chk("t3_writes", 32'(wr_count - b), 32'd3);

        // 4: MAX_BURST=4 forced release; r1 streams 6 beats, r3 waiting
        for (int i = 1; i <= 6; i++) push(1, 8'(8'h40 + i), (i == 6) ? 1'b1 : 1'b0);
        push(3, 8'h4F, 1'b1);
        expw(10'h141); expw(10'h142); expw(10'h143); expw(10'h144);
        expw(10'h34F);
        expw(10'h145); expw(10'h146);
        drain("t4");

        // 6: owner r2 idles mid-burst while r0 is valid (with last); grant holds
        b = wr_count;
        push(2, 8'h61, 1'b0); push(0, 8'h71, 1'b1);
        expw(10'h261);
        wait_writes("t6", b + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_hold_grant", 32'(grant), 32'h4);
            chk("t6_hold_wr_en", 32'(fifo_wr_en), 32'd0);
            @(posedge clk);
        end
        #2;
        push(2, 8'h62, 1'b1);
        expw(10'h262); expw(10'h071);
        drain("t6");

        // 5: reset during beat 2 of r3's burst, then rr_ptr restarts at 0
        b = wr_count;
        push(3, 8'h51, 1'b0); push(3, 8'h52, 1'b0); push(3, 8'h53, 1'b1);
        expw(10'h351);
        wait_writes("t5", b + 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        push(0, 8'h80, 1'b1); push(3, 8'h83, 1'b1);
        expw(10'h080); expw(10'h383);
        drain("t5");

        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
